powlib_up_fifo: RTL and testbench

//  Single-clock upsizing FIFO (implements DUT powlib_upfifo). Packs MULT consecutive W-bit

---
 rtl/powlib_up_fifo.sv | 104 ++++++++++
 tb/tb_powlib_up_fifo.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/powlib_up_fifo.sv
// Single-clock upsizing FIFO: packs MULT narrow words into one wide word and
// buffers packed words in a D-deep show-ahead queue with valid/ready on both sides.
module powlib_up_fifo #(
  parameter int unsigned W      = 16,
  parameter int unsigned MULT   = 3,
  parameter int unsigned D      = 8,
  parameter int          EASYNC = 0,
  parameter int          EAR    = 0,
  parameter string       ID     = "UPFIFO",
  parameter int          EDBG   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W-1:0]      wrdata,
  input  logic              wrvld,
  output logic              wrrdy,
  output logic [W*MULT-1:0] rddata,
  output logic              rdvld,
  input  logic              rdrdy
);

  localparam int unsigned CW = (MULT > 1) ? $clog2(MULT) : 1;
  localparam int unsigned AW = $clog2(D);
  localparam int unsigned OW = W * MULT;
  localparam int unsigned PW = W * (MULT - 1);

  if (EASYNC != 0) begin : g_async_unsupported
    $error("%s: EASYNC=%0d (EAR=%0d) not supported, single clock only", ID, EASYNC, EAR);
  end

  logic [CW-1:0] cnt;
  logic [PW-1:0] partial;
  logic [OW-1:0] mem [D];
  logic [AW-1:0] wrptr;
  logic [AW-1:0] rdptr;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;
  logic          wr_acc;
  logic          last_lane;
  logic          push;
  logic          pop;

  // Transfer decode and next occupancy
  always_comb begin
    wr_acc    = wrvld & wrrdy;
    last_lane = (cnt == CW'(MULT - 1));
    push      = wr_acc & last_lane;
    pop       = rdvld & rdrdy;
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + (AW+1)'(1);
    end else if (pop && !push) begin
      count_nxt = count - (AW+1)'(1);
    end
  end

  // Lane packing, pointers and registered flags derived from next occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      partial <= '0;
      wrptr   <= '0;
      rdptr   <= '0;
      count   <= '0;
      rdvld   <= 1'b0;
      wrrdy   <= 1'b1;
    end else begin
      if (wr_acc) begin
        cnt <= last_lane ? '0 : cnt + CW'(1);
      end
      for (int unsigned i = 0; i < MULT - 1; i++) begin
        if (wr_acc && (cnt == CW'(i))) begin
          partial[W*i +: W] <= wrdata;
        end
      end
      if (push) begin
        wrptr <= wrptr + AW'(1);
      end
      if (pop) begin
        rdptr <= rdptr + AW'(1);
      end
      count <= count_nxt;
      rdvld <= (count_nxt != '0);
      wrrdy <= (count_nxt != (AW+1)'(D));
    end
  end

  // Final lane goes straight into storage alongside the held partial lanes
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wrptr] <= {wrdata, partial};
    end
  end

  assign rddata = rdvld ? mem[rdptr] : '0;

  if (EDBG != 0) begin : g_dbg
    always_ff @(posedge clk) begin
      if (!rst && wr_acc) $display("%s wr %h", ID, wrdata);
      if (!rst && pop)    $display("%s rd %h", ID, rddata);
    end
  end

endmodule

// File: tb/tb_powlib_up_fifo.sv
// Randomized self-checking bench for powlib_up_fifo against a queue-based
// reference model (W=16, MULT=3, D=8).
module tb_powlib_up_fifo;

  localparam int unsigned W    = 16;
  localparam int unsigned MULT = 3;
  localparam int unsigned D    = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [W-1:0]      wrdata;
  logic              wrvld;
  logic              wrrdy;
  logic [W*MULT-1:0] rddata;
  logic              rdvld;
  logic              rdrdy;

  int checks = 0;
  int errors = 0;

  logic [W*MULT-1:0] mq[$];
  logic [W-1:0]      part[$];

  powlib_up_fifo #(.W(W), .MULT(MULT), .D(D)) dut (
    .clk(clk), .rst(rst),
    .wrdata(wrdata), .wrvld(wrvld), .wrrdy(wrrdy),
    .rddata(rddata), .rdvld(rdvld), .rdrdy(rdrdy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: collect narrow words, emit one wide word per MULT, first word in LSBs
  function automatic void model_write(input logic [W-1:0] d);
    logic [W*MULT-1:0] w;
    part.push_back(d);
    if (part.size() == MULT) begin
      w = '0;
      for (int i = 0; i < MULT; i++) w[W*i +: W] = part[i];
      mq.push_back(w);
      part.delete();
    end
  endfunction

  function automatic void model_reset();
    mq.delete();
    part.delete();
  endfunction

  task automatic do_reset();
    rst = 1'b1; wrvld = 1'b0; rdrdy = 1'b0; wrdata = '0;
    tick(); tick();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    checks++; if (rdvld !== 1'b0) begin errors++; $display("FAIL reset_rdvld got %b want 0", rdvld); end
    checks++; if (wrrdy !== 1'b1) begin errors++; $display("FAIL reset_wrrdy got %b want 1", wrrdy); end
    checks++; if (rddata !== '0) begin errors++; $display("FAIL reset_rddata got %h want 0", rddata); end
  endtask

  task automatic test_basic_pack();
    logic [W-1:0] words [3];
    words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333;
    rdrdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (rdvld !== 1'b0) begin errors++; $display("FAIL basic_early_rdvld lane %0d got %b want 0", i, rdvld); end
      wrvld = 1'b1; wrdata = words[i];
      tick();
    end
    wrvld = 1'b0;
    checks++; if (rdvld !== 1'b1) begin errors++; $display("FAIL basic_rdvld got %b want 1", rdvld); end
    checks++; if (rddata !== 48'h333322221111) begin errors++; $display("FAIL basic_rddata got %h want 333322221111", rddata); end
    rdrdy = 1'b1;
    tick();
    rdrdy = 1'b0;
    checks++; if (rdvld !== 1'b0) begin errors++; $display("FAIL basic_pop_rdvld got %b want 0", rdvld); end
    checks++; if (rddata !== '0) begin errors++; $display("FAIL basic_empty_rddata got %h want 0", rddata); end
  endtask

  task automatic test_partial_reset();
    wrvld = 1'b1; wrdata = 16'h5555; tick();
    wrdata = 16'h6666; tick();
    wrvld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (rdvld !== 1'b0) begin errors++; $display("FAIL partial_rdvld cycle %0d got %b want 0", i, rdvld); end
    end
    do_reset();
    wrvld = 1'b1; wrdata = 16'hAAAA; tick();
    wrdata = 16'hBBBB; tick();
    wrdata = 16'hCCCC; tick();
    wrvld = 1'b0;
    checks++; if (rdvld !== 1'b1) begin errors++; $display("FAIL partial_after_rst_rdvld got %b want 1", rdvld); end
    checks++; if (rddata !== 48'hCCCCBBBBAAAA) begin errors++; $display("FAIL partial_after_rst_rddata got %h want ccccbbbbaaaa", rddata); end
    rdrdy = 1'b1; tick(); rdrdy = 1'b0;
    checks++; if (rdvld !== 1'b0) begin errors++; $display("FAIL partial_drain_rdvld got %b want 0", rdvld); end
  endtask

  task automatic test_full();
    logic [W-1:0] d;
    do_reset();
    rdrdy = 1'b0;
    for (int i = 0; i < 24; i++) begin
      checks++; if (wrrdy !== 1'b1) begin errors++; $display("FAIL full_fill_wrrdy word %0d got %b want 1", i, wrrdy); end
      d = W'($urandom);
      wrvld = 1'b1; wrdata = d;
      model_write(d);
      tick();
    end
    checks++; if (wrrdy !== 1'b0) begin errors++; $display("FAIL full_wrrdy got %b want 0", wrrdy); end
    // Writes against a full queue must vanish
    for (int i = 0; i < 4; i++) begin
      wrdata = W'($urandom);
      tick();
      checks++; if (wrrdy !== 1'b0) begin errors++; $display("FAIL full_hold_wrrdy cycle %0d got %b want 0", i, wrrdy); end
    end
    wrvld = 1'b0;
    rdrdy = 1'b1;
    for (int i = 0; i < D; i++) begin
      checks++; if (rdvld !== 1'b1) begin errors++; $display("FAIL drain_rdvld word %0d got %b want 1", i, rdvld); end
      checks++; if (rddata !== mq[0]) begin errors++; $display("FAIL drain_rddata word %0d got %h want %h", i, rddata, mq[0]); end
      void'(mq.pop_front());
      tick();
      if (i == 0) begin
        checks++; if (wrrdy !== 1'b1) begin errors++; $display("FAIL drain_wrrdy_return got %b want 1", wrrdy); end
      end
    end
    rdrdy = 1'b0;
    checks++; if (rdvld !== 1'b0) begin errors++; $display("FAIL drain_empty_rdvld got %b want 0", rdvld); end
  endtask

  task automatic test_stream();
    int written = 0;
    int popped  = 0;
    int cycles  = 0;
    bit exp_wrrdy;
    bit exp_rdvld;
    logic [W-1:0] d;
    do_reset();
    while ((written < 3000 || mq.size() != 0) && cycles < 20000) begin
      cycles++;
      wrvld  = (written < 3000) && ($urandom_range(3, 0) != 0);
      d      = W'($urandom);
      wrdata = d;
      rdrdy  = ($urandom_range(3, 0) != 0);
      exp_wrrdy = (mq.size() != D);
      exp_rdvld = (mq.size() != 0);
      #1;
      checks++; if (wrrdy !== exp_wrrdy) begin errors++; $display("FAIL stream_wrrdy cycle %0d got %b want %b", cycles, wrrdy, exp_wrrdy); end
      checks++; if (rdvld !== exp_rdvld) begin errors++; $display("FAIL stream_rdvld cycle %0d got %b want %b", cycles, rdvld, exp_rdvld); end
      if (exp_rdvld) begin
        checks++; if (rddata !== mq[0]) begin errors++; $display("FAIL stream_rddata pop %0d got %h want %h", popped, rddata, mq[0]); end
      end
      if (exp_rdvld && rdrdy) begin
        void'(mq.pop_front());
        popped++;
      end
      if (wrvld && exp_wrrdy) begin
        model_write(d);
        written++;
      end
      tick();
    end
    wrvld = 1'b0; rdrdy = 1'b0;
    checks++; if (popped !== 1000) begin errors++; $display("FAIL stream_pop_count got %0d want 1000 (cycles %0d)", popped, cycles); end
  endtask

  initial begin
    rst = 1'b1; wrvld = 1'b0; rdrdy = 1'b0; wrdata = '0;
    test_reset();
    test_basic_pack();
    test_partial_reset();
    test_full();
    test_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
